// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Shift levels work on a 64-bit, MSB-aligned copy of the operand so one helper serves every width.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

    localparam int MAX_N = 64;

    // Levels owned by group idx when total levels are split into stages groups of ceil(total/stages).
    function automatic int group_levels(input int total, input int stages, input int idx);
        int per;
        int rem;
        per = (total + stages - 32'sd1) / stages;
        rem = total - idx * per;
        if (rem <= 32'sd0) begin
            return 32'sd0;
        end else if (rem < per) begin
            return rem;
        end else begin
            return per;
        end
    endfunction

    // data is MSB-aligned; fill is LSB-aligned and its low 'amount' bits enter at the top on right shifts.
    function automatic logic [MAX_N-1:0] shift_level(
        input logic [MAX_N-1:0] data,
        input shift_mode_t      mode,
        input logic [MAX_N-1:0] fill,
        input int unsigned      amount
    );
        logic [MAX_N-1:0] res;
        case (mode)
            SHIFT_SLL: res = data << amount;
            default:   res = (data >> amount) | (fill << (MAX_N - amount));
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline group: a run of shift levels followed by its register bank.
// The bank holds its contents whenever the pipe is stalled.
module shift_stage
    import shift_pkg::*;
#(
    parameter int N           = 32,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 src_valid,
    input  logic [N-1:0]         src_data,
    input  logic [$clog2(N)-1:0] src_shamt,
    input  shift_mode_t          src_mode,
    input  logic                 src_sign,
    output logic                 valid,
    output logic [N-1:0]         data,
    output logic [$clog2(N)-1:0] shamt,
    output shift_mode_t          mode,
    output logic                 sign
);

    logic [MAX_N-1:0] level [0:NUM_LEVELS];
    logic [MAX_N-1:0] sign_fill;

    assign sign_fill = src_sign ? MAX_N'({N{1'b1}}) : {MAX_N{1'b0}};
    assign level[0]  = MAX_N'(src_data) << (MAX_N - N);

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        logic [MAX_N-1:0] fill;

        // Rotation re-reads the current word; SRA uses the sign captured at the pipe input.
        always_comb begin
            case (src_mode)
                SHIFT_SRA: fill = sign_fill;
                SHIFT_ROR: fill = level[g] >> (MAX_N - N);
                default:   fill = {MAX_N{1'b0}};
            endcase
        end

        assign level[g+1] = src_shamt[FIRST_LEVEL+g]
                          ? shift_level(level[g], src_mode, fill, 32'd1 << (FIRST_LEVEL + g))
                          : level[g];
    end

    // Register bank; invalid beats still advance so the pipe never compresses bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= {N{1'b0}};
            shamt <= {$clog2(N){1'b0}};
            mode  <= SHIFT_SLL;
            sign  <= 1'b0;
        end else if (advance) begin
            valid <= src_valid;
            data  <= level[NUM_LEVELS][MAX_N-1 -: N];
            shamt <= src_shamt;
            mode  <= src_mode;
            sign  <= src_sign;
        end else begin
            valid <= valid;
            data  <= data;
            shamt <= shamt;
            mode  <= mode;
            sign  <= sign;
        end
    end

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready handshake.
// The whole pipe advances together; only a stalled output holds it.
module shift_unit_pipelined
    import shift_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);

    localparam int L     = $clog2(N);
    localparam int GROUP = (L + STAGES - 1) / STAGES;

    logic          pipe_valid [0:STAGES];
    logic [N-1:0]  pipe_data  [0:STAGES];
    logic [L-1:0]  pipe_shamt [0:STAGES];
    shift_mode_t   pipe_mode  [0:STAGES];
    logic          pipe_sign  [0:STAGES];
    logic          advance;

    assign pipe_valid[0] = in_valid;
    assign pipe_data[0]  = in_data;
    assign pipe_shamt[0] = in_shamt;
    assign pipe_mode[0]  = shift_mode_t'(in_mode);
    assign pipe_sign[0]  = in_data[N-1];

    assign advance   = !(pipe_valid[STAGES] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = pipe_valid[STAGES];
    assign out_data  = pipe_data[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .N           (N),
            .FIRST_LEVEL (s * GROUP),
            .NUM_LEVELS  (group_levels(L, STAGES, s))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .src_valid (pipe_valid[s]),
            .src_data  (pipe_data[s]),
            .src_shamt (pipe_shamt[s]),
            .src_mode  (pipe_mode[s]),
            .src_sign  (pipe_sign[s]),
            .valid     (pipe_valid[s+1]),
            .data      (pipe_data[s+1]),
            .shamt     (pipe_shamt[s+1]),
            .mode      (pipe_mode[s+1]),
            .sign      (pipe_sign[s+1])
        );
    end

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Directed bench for shift_unit_pipelined (N=32, STAGES=2) plus an N=8 sweep
// of STAGES=1 and STAGES=3 against a behavioural model.
module tb_shift_unit_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;

    logic        s_in_valid [2];
    logic        s_in_ready [2];
    logic        s_out_valid[2];
    logic        s_out_ready[2];
    logic [7:0]  s_in_data  [2];
    logic [7:0]  s_out_data [2];
    logic [2:0]  s_in_shamt [2];
    logic [1:0]  s_in_mode  [2];

    int n_cmp;
    int n_bad;

    shift_unit_pipelined #(.N(32), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    shift_unit_pipelined #(.N(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]), .in_data(s_in_data[0]),
        .in_shamt(s_in_shamt[0]), .in_mode(s_in_mode[0]),
        .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]), .out_data(s_out_data[0])
    );

    shift_unit_pipelined #(.N(8), .STAGES(3)) u_s3 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]), .in_data(s_in_data[1]),
        .in_shamt(s_in_shamt[1]), .in_mode(s_in_mode[1]),
        .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]), .out_data(s_out_data[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                              input logic [1:0] m, input int n);
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] r;
        mask = (64'd1 << n) - 64'd1;
        v = d & mask;
        case (m)
            2'b00:   r = v << sh;
            2'b01:   r = v >> sh;
            2'b10:   r = (v >> sh) | (v[n-1] ? (mask & ~(mask >> sh)) : 64'd0);
            default: r = (v >> sh) | (v << (n - sh));
        endcase
        return r & mask;
    endfunction

    task automatic one_beat(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                            input logic [31:0] exp, input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
    endtask

    logic [31:0] bp_exp [4];
    logic [7:0]  exp_mem [2][1000];
    int          sent, got, stall_left, stall_cnt;
    logic        seen_first, prev_stall, stalled;
    logic [31:0] prev_data;
    int          acc [2];
    int          rcv [2];
    logic        pend [2];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; in_shamt = 5'd0; in_mode = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_in_valid[i] = 1'b0; s_in_data[i] = 8'd0; s_in_shamt[i] = 3'd0;
            s_in_mode[i] = 2'b00; s_out_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        one_beat(32'h8000_00F1, 5'd4, 2'b00, 32'h0000_0F10, "sll4");
        one_beat(32'h8000_00F1, 5'd4, 2'b01, 32'h0800_000F, "srl4");
        one_beat(32'h8000_00F1, 5'd4, 2'b10, 32'hF800_000F, "sra4");
        one_beat(32'h8000_00F1, 5'd4, 2'b11, 32'h1800_000F, "ror4");

        one_beat(32'h8000_0001, 5'd0, 2'b00, 32'h8000_0001, "sll0");
        one_beat(32'h8000_0001, 5'd0, 2'b01, 32'h8000_0001, "srl0");
        one_beat(32'h8000_0001, 5'd0, 2'b10, 32'h8000_0001, "sra0");
        one_beat(32'h8000_0001, 5'd0, 2'b11, 32'h8000_0001, "ror0");
        one_beat(32'h8000_0001, 5'd31, 2'b01, 32'h0000_0001, "srl31");
        one_beat(32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF, "sra31");
        one_beat(32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000, "sll31");
        one_beat(32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003, "ror31");

        // Back-to-back stream: beat j-2 must be on the output at iteration j.
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (j < 10);
            in_data   = 32'(j);
            in_shamt  = 5'(j);
            in_mode   = 2'b00;
            #1;
            if (j < 10) check("stream_in_ready", 64'(in_ready), 64'd1);
            if (j < 2) begin
                check("stream_idle", 64'(out_valid), 64'd0);
            end else begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_data", 64'(out_data), 64'(32'(j - 2) << (j - 2)));
            end
        end
        in_valid = 1'b0;

        // Backpressure: four SRL-by-1 beats, output stalled for three cycles.
        bp_exp[0] = 32'h0000_0080; bp_exp[1] = 32'h0000_0100;
        bp_exp[2] = 32'h0000_0180; bp_exp[3] = 32'h0000_0200;
        sent = 0; got = 0; stall_left = 0; stall_cnt = 0;
        seen_first = 1'b0; prev_stall = 1'b0; prev_data = 32'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid && !seen_first) begin
                seen_first = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 4);
            in_data  = 32'(sent + 1) << 8;
            in_shamt = 5'd1;
            in_mode  = 2'b01;
            #1;
            stalled = out_valid && !out_ready;
            if (stalled) begin
                stall_cnt++;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                if (prev_stall) check("bp_hold", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (got < 4) check("bp_order", 64'(out_data), 64'(bp_exp[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = stalled;
            prev_data  = out_data;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(got), 64'd4);
        check("bp_stall_cycles", 64'(stall_cnt), 64'd3);

        // Reset with two beats in flight.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_00A5; in_shamt = 5'd1; in_mode = 2'b00;
        @(negedge clk);
        in_data = 32'h0000_005A;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_result", 64'(out_valid), 64'd0);
        end

        // N=8 sweep: STAGES=1 (index 0) and STAGES=3 (index 1), random ready.
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; rcv[i] = 0; pend[i] = 1'b0;
        end
        for (int c = 0; c < 6000 && (rcv[0] < 1000 || rcv[1] < 1000); c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    s_in_valid[i] = (acc[i] < 1000) && ($urandom_range(0, 4) != 0);
                    s_in_data[i]  = 8'($urandom);
                    s_in_shamt[i] = 3'($urandom_range(0, 7));
                    s_in_mode[i]  = 2'($urandom_range(0, 3));
                end
                s_out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (s_out_valid[i] && s_out_ready[i]) begin
                    if (rcv[i] < 1000)
                        check(i == 0 ? "sweep_s1_data" : "sweep_s3_data",
                              64'(s_out_data[i]), 64'(exp_mem[i][rcv[i]]));
                    rcv[i]++;
                end
                if (s_in_valid[i] && s_in_ready[i]) begin
                    exp_mem[i][acc[i]] = 8'(ref_shift(64'(s_in_data[i]), int'(s_in_shamt[i]),
                                                      s_in_mode[i], 8));
                    acc[i]++;
                    pend[i] = 1'b0;
                end else begin
                    pend[i] = s_in_valid[i];
                end
            end
        end
        for (int i = 0; i < 2; i++) s_in_valid[i] = 1'b0;
        check("sweep_s1_count", 64'(rcv[0]), 64'd1000);
        check("sweep_s3_count", 64'(rcv[1]), 64'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
